alu_op_issue: RTL and testbench

- Operand issue stage directly upstream of the combinational N-bit ALU.
- Buffers operation requests (A, B, mode) in a small FIFO and presents the head entry to the ALU's Ain/Bin/mode inputs.
- Captures the ALU result into an output register with a valid/ready handshake.
- A chain flag lets an operation use the previously issued result as its A operand, so dependent sequences (e.g. accumulate, then subtract) run back-to-back.

---
 rtl/alu_op_issue_pkg.sv | 18 +
 rtl/alu_req_fifo.sv | 64 ++++++
 rtl/alu_op_issue.sv | 110 +++++++++++
 tb/tb_alu_op_issue.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_issue_pkg.sv
// Shared types and constants for the ALU operand issue stage.
package alu_op_issue_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_ADD = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SUB = 3'd1;

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_e;

    function automatic int data_width(input int n1);
        return n1 * 8;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO; head entry is visible on rdata_o.
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [DW-1:0]          wdata_i,
    output logic [DW-1:0]          rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_op_issue.sv
// Operand issue stage: queues ALU requests, drives the ALU from the
// FIFO head and registers the result behind a valid/ready handshake.
module alu_op_issue
    import alu_op_issue_pkg::*;
#(
    parameter  int N1    = 8,
    parameter  int DEPTH = 4,
    localparam int W     = data_width(N1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    input  logic [MODE_W-1:0]      in_mode,
    input  logic                   in_chain,
    output logic [W-1:0]           alu_a,
    output logic [W-1:0]           alu_b,
    output logic [MODE_W-1:0]      alu_mode,
    input  logic [W-1:0]           alu_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_result,
    output logic [MODE_W-1:0]      out_mode,
    output logic [$clog2(DEPTH):0] count
);

    typedef struct packed {
        logic [W-1:0]      a;
        logic [W-1:0]      b;
        logic [MODE_W-1:0] mode;
        logic              chain;
    } req_t;

    req_t                wreq;
    req_t                head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                issue;

    out_state_e          state_q, state_d;
    logic [W-1:0]        res_q, res_d;
    logic [MODE_W-1:0]   omode_q, omode_d;
    logic [W-1:0]        acc_q, acc_d;

    assign wreq = '{a: in_a, b: in_b, mode: in_mode, chain: in_chain};

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .DW    ($bits(req_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (issue),
        .wdata_i (wreq),
        .rdata_o (head),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign out_valid = (state_q == OUT_FULL);
    assign issue     = !fifo_empty && (!out_valid || out_ready);

    assign alu_a    = fifo_empty ? '0 : (head.chain ? acc_q : head.a);
    assign alu_b    = fifo_empty ? '0 : head.b;
    assign alu_mode = fifo_empty ? '0 : head.mode;

    assign out_result = res_q;
    assign out_mode   = omode_q;

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        omode_d = omode_q;
        acc_d   = acc_q;
        unique case (state_q)
            OUT_EMPTY: if (issue) state_d = OUT_FULL;
            OUT_FULL:  if (out_ready && !issue) state_d = OUT_EMPTY;
            default:   state_d = OUT_EMPTY;
        endcase
        // acc follows every issue so a chained op right behind can use it.
        if (issue) begin
            res_d   = alu_result;
            omode_d = head.mode;
            acc_d   = alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OUT_EMPTY;
            res_q   <= '0;
            omode_q <= MODE_ADD;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            omode_q <= omode_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed plus random bench for alu_op_issue with an in-order result model.
module tb_alu_op_issue;
    import alu_op_issue_pkg::*;

    localparam int N1    = 8;
    localparam int DEPTH = 4;
    localparam int W     = N1 * 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [2:0]    in_mode;
    logic          in_chain;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2:0]    alu_mode;
    logic [W-1:0]  alu_result;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [2:0]    out_mode;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    alu_op_issue #(.N1(N1), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mode    (in_mode),
        .in_chain   (in_chain),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_mode   (alu_mode),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_mode   (out_mode),
        .count      (count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [2:0]   m);
        case (m)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Combinational ALU sitting downstream of the stage.
    always_comb alu_result = ref_alu(alu_a, alu_b, alu_mode);

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] m, input logic c);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
        in_chain = c;
    endtask

    // Reference: results are in request order, computed at acceptance.
    typedef struct {
        logic [W-1:0] r;
        logic [2:0]   m;
    } exp_t;

    exp_t         expq[$];
    logic [W-1:0] macc;
    logic         hold_v;
    logic [W-1:0] hold_r;
    logic [2:0]   hold_m;

    always @(negedge clk) begin
        exp_t         e;
        logic [W-1:0] aeff;
        if (!rst_n) begin
            expq.delete();
            macc   = '0;
            hold_v = 1'b0;
        end else begin
            chk("occupancy", 64'(count) + 64'(out_valid), 64'(expq.size()));
            chk("in_ready", in_ready, 64'(count < DEPTH));
            if (hold_v && out_valid) begin
                chk("hold_result", out_result, hold_r);
                chk("hold_mode", out_mode, hold_m);
            end
            hold_v = out_valid && !out_ready;
            hold_r = out_result;
            hold_m = out_mode;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_out", out_valid, 0);
                end else begin
                    e = expq.pop_front();
                    chk("result", out_result, e.r);
                    chk("mode", out_mode, e.m);
                end
            end
            if (in_valid && in_ready) begin
                aeff = in_chain ? macc : in_a;
                e.r  = ref_alu(aeff, in_b, in_mode);
                e.m  = in_mode;
                macc = e.r;
                expq.push_back(e);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mode   = MODE_ADD;
        in_chain  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        // asynchronous reset mid-cycle
        set_op({$urandom, $urandom}, {$urandom, $urandom}, MODE_ADD, 1'b0);
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_mode", alu_mode, 0);
        tick();
        rst_n = 1'b1;

        // single add, two-edge latency
        set_op(64'h44, 64'h33, MODE_ADD, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("single_count", count, 1);
        chk("single_early_valid", out_valid, 0);
        chk("single_alu_a", alu_a, 64'h44);
        chk("single_alu_b", alu_b, 64'h33);
        tick();
        chk("single_valid", out_valid, 1);
        chk("single_result", out_result, 64'h77);
        chk("single_mode", out_mode, MODE_ADD);
        tick();
        chk("single_drained", out_valid, 0);

        // dependent pair, back-to-back
        set_op(64'h10, 64'h05, MODE_ADD, 1'b0);
        tick();
        set_op({$urandom, $urandom}, 64'h03, MODE_SUB, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("chain_first", out_result, 64'h15);
        chk("chain_alu_a", alu_a, 64'h15);
        tick();
        chk("chain_second_valid", out_valid, 1);
        chk("chain_second", out_result, 64'h12);
        chk("chain_second_mode", out_mode, MODE_SUB);
        set_op({$urandom, $urandom}, 64'h0, MODE_ADD, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("acc_after_chain", out_result, 64'h12);
        tick();

        // backpressure fills the FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_op({$urandom, $urandom}, {$urandom, $urandom},
                   3'($urandom_range(0, 7)), 1'($urandom));
            tick();
        end
        chk("bp_count", count, DEPTH);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        set_op({$urandom, $urandom}, {$urandom, $urandom}, MODE_SUB, 1'b1);
        tick();
        chk("bp_op6_stall", count, DEPTH);
        tick();
        chk("bp_op6_still", count, DEPTH);
        out_ready = 1'b1;
        tick();
        chk("full_pop_count", count, DEPTH - 1);
        chk("full_pop_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("push_pop_count", count, DEPTH - 1);
        repeat (6) tick();
        chk("bp_drain_count", count, 0);
        chk("bp_drain_valid", out_valid, 0);

        // reset with work in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_op({$urandom, $urandom} | 64'h1, 64'h0, MODE_ADD, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        chk("mid_count", count, 3);
        chk("mid_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_result", out_result, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        set_op({$urandom, $urandom}, 64'h01, MODE_ADD, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("post_rst_chain_a", alu_a, 0);
        tick();
        chk("post_rst_chain_res", out_result, 64'h01);
        tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom);
            in_a      = {$urandom, $urandom};
            in_b      = {$urandom, $urandom};
            in_mode   = 3'($urandom_range(0, 7));
            in_chain  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        chk("final_drain", 64'(count) + 64'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
